ps2_mouse_init_ctrl: RTL and testbench
======================================

Name: ps2_mouse_init_ctrl

Overview:
- Sequences the PS/2 mouse link between a host byte transmitter and the mouse receive datapath.
- After a start request it runs the mouse bring-up handshake: reset, ACK, BAT, ID, enable reporting, ACK.
- It then frames the received byte stream into 3-byte movement packets for the APB-side FIFO/IRQ logic.
- It handles retries, timeouts and error reporting.

Parameters:
- TIMEOUT_CYC, 2000000, hclk cycles allowed while waiting for any expected device byte; also the inter-byte gap limit in STREAM.
- MAX_RETRY, 3, maximum command retries before entering ERROR.

Ports:
- hclk  in  1  clock
- hrst  in  1  reset, synchronous, active-high
- start_i  in  1  single-cycle pulse; begins or restarts initialisation
- tx_valid_o  out  1  command byte offered to the host transmitter
- tx_data_o  out  8  command byte
- tx_ready_i  in  1  transmitter accepts the byte (transfer when tx_valid_o && tx_ready_i)
- tx_done_i  in  1  pulse: byte shifted out and device line-ACK bit seen
- tx_err_i  in  1  pulse: transmission failed (no line-ACK, or clock timeout)
- rx_valid_i  in  1  pulse: parity/frame-checked byte from the receive datapath
- rx_data_i  in  8  received byte
- pkt_valid_o  out  1  one-cycle pulse: complete packet on pkt_data_o
- pkt_data_o  out  24  [7:0]=status byte, [15:8]=X, [23:16]=Y
- ready_o  out  1  high while in STREAM
- busy_o  out  1  high in any state other than IDLE, STREAM or ERROR
- err_o  out  1  high while in ERROR
- err_code_o  out  2  0 none, 1 retries exhausted, 2 BAT failed (0xFC), 3 unexpected device ID

Behaviour:
- Reset: state IDLE. All outputs are 0, including tx_data_o and pkt_data_o. Retry counter, timeout counter and byte index are 0.
- States: IDLE, TX_REQ, TX_WAIT, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAM, ERROR. Register cmd holds 0xFF (reset) or 0xF4 (enable).
- IDLE: on start_i, load cmd=0xFF, clear retries and err_code, go to TX_REQ. start_i is also honoured in STREAM and ERROR, with the same action. It is ignored in all other states.
- TX_REQ: tx_valid_o=1 and tx_data_o=cmd, held stable until tx_ready_i. On the transfer cycle go to TX_WAIT; tx_valid_o drops the next cycle.
- TX_WAIT:
  - tx_done_i -> WAIT_ACK.
  - tx_err_i -> retry.
  - If both arrive in the same cycle, tx_err_i wins.
- WAIT_ACK:
  - rx 0xFA: if cmd=0xFF go to WAIT_BAT; if cmd=0xF4 go to STREAM.
  - rx 0xFE, any other byte, or timeout -> retry.
- WAIT_BAT: rx 0xAA -> WAIT_ID. rx 0xFC -> ERROR with code 2. Any other byte is ignored. Timeout -> retry with cmd forced to 0xFF.
- WAIT_ID: rx 0x00 -> load cmd=0xF4, clear retries, go to TX_REQ. Any other byte -> ERROR with code 3. Timeout -> retry.
- Retry rule: if retries==MAX_RETRY, go to ERROR with code 1. Otherwise increment retries and go to TX_REQ, keeping cmd except as noted for WAIT_BAT.
- Timeout counter:
  - Cleared on every state entry and on every rx_valid_i.
  - Counts in WAIT_* states and in STREAM.
  - Timeout fires when count reaches TIMEOUT_CYC-1.
- rx_valid_i in IDLE, TX_REQ, TX_WAIT or ERROR is dropped.
- STREAM framing:
  - Byte index idx goes 0, 1, 2.
  - At idx 0, a byte with bit3=0 is discarded (resync) and idx stays 0.
  - At idx 2, the byte completes the packet. pkt_data_o updates and pkt_valid_o pulses in the cycle after that rx_valid_i; idx returns to 0.
  - pkt_data_o holds its value between packets.
  - An inter-byte timeout with idx != 0 discards the partial packet and sets idx=0. A timeout with idx=0 has no effect.
- Restart from STREAM abandons any partial packet.
- hrst mid-operation forces IDLE in the same edge and drops tx_valid_o immediately.
- ERROR: err_o=1 and err_code_o is held until start_i or hrst.

Test Plan:
- Normal bring-up (TIMEOUT_CYC=100, MAX_RETRY=2): start; tx 0xFF done; rx FA, AA, 00; tx 0xF4 done; rx FA -> ready_o=1, err_o=0, exactly two tx transfers, 0xFF then 0xF4.
- NAK retry: first reply to 0xFF is 0xFE, then normal sequence -> 0xFF transmitted twice, ready_o=1. tx_err_i on 0xF4 three times -> err_o=1, err_code_o=1.
- BAT fail: rx FA then FC -> err_o=1, err_code_o=2. Then start_i with normal sequence -> ready_o=1, err_code_o=0.
- Bad ID (rx FA, AA, 03) -> err_code_o=3. No reply after 0xFF -> three 0xFF sends spaced ≥100 cycles, then err_code_o=1.
- Stream framing: rx 0x05 (bit3=0, dropped), 0x09, 0x10, 0xF0 -> a single pkt_valid_o pulse with pkt_data_o=0xF01009.
- Inter-byte timeout: rx 0x08, 0x01, gap of 100 cycles, then 0x08, 0x02, 0x03 -> a single packet 0x030208. tx_valid_o held under tx_ready_i=0 for 10 cycles with tx_data_o stable; hrst asserted mid-TX_REQ -> tx_valid_o=0 next cycle, state IDLE.

Source files
------------

// File: rtl/ps2_mouse_init_ctrl.sv
// rtl/ps2_mouse_init_ctrl.sv - PS/2 mouse bring-up sequencer and 3-byte movement packet framer
module ps2_mouse_init_ctrl #(
    parameter int TIMEOUT_CYC = 2000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        start_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    input  logic        tx_done_i,
    input  logic        tx_err_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        pkt_valid_o,
    output logic [23:0] pkt_data_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;

    typedef enum logic [2:0] {
        IDLE, TX_REQ, TX_WAIT, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAM, ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    b0_q, b0_d, b1_q, b1_d;
    logic [23:0]   pkt_data_q, pkt_data_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          counting, timeout, do_retry;

    assign counting = (state_q == WAIT_ACK) || (state_q == WAIT_BAT) ||
                      (state_q == WAIT_ID)  || (state_q == STREAM);
    assign timeout  = counting && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        retry_d     = retry_q;
        err_code_d  = err_code_q;
        idx_d       = idx_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = 1'b0;
        do_retry    = 1'b0;

        case (state_q)
            TX_REQ: if (tx_ready_i) state_d = TX_WAIT;
            TX_WAIT: begin
                if (tx_err_i)       do_retry = 1'b1;
                else if (tx_done_i) state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (rx_valid_i) begin
                    if (rx_data_i == 8'hFA) begin
                        state_d = (cmd_q == CMD_RESET) ? WAIT_BAT : STREAM;
                        idx_d   = 2'd0;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (timeout) begin
                    do_retry = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (rx_valid_i) begin
                    if (rx_data_i == 8'hAA) begin
                        state_d = WAIT_ID;
                    end else if (rx_data_i == 8'hFC) begin
                        state_d    = ERROR;
                        err_code_d = 2'd2;
                    end
                end else if (timeout) begin
                    cmd_d    = CMD_RESET;
                    do_retry = 1'b1;
                end
            end
            WAIT_ID: begin
                if (rx_valid_i) begin
                    if (rx_data_i == 8'h00) begin
                        cmd_d   = CMD_ENABLE;
                        retry_d = '0;
                        state_d = TX_REQ;
                    end else begin
                        state_d    = ERROR;
                        err_code_d = 2'd3;
                    end
                end else if (timeout) begin
                    do_retry = 1'b1;
                end
            end
            STREAM: begin
                if (rx_valid_i) begin
                    case (idx_q)
                        2'd0: if (rx_data_i[3]) begin
                            b0_d  = rx_data_i;
                            idx_d = 2'd1;
                        end
                        2'd1: begin
                            b1_d  = rx_data_i;
                            idx_d = 2'd2;
                        end
                        default: begin
                            pkt_data_d  = {rx_data_i, b1_q, b0_q};
                            pkt_valid_d = 1'b1;
                            idx_d       = 2'd0;
                        end
                    endcase
                end else if (timeout) begin
                    idx_d = 2'd0;
                end
            end
            default: ;
        endcase

        if (do_retry) begin
            if (retry_q == RW'(MAX_RETRY)) begin
                state_d    = ERROR;
                err_code_d = 2'd1;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = TX_REQ;
            end
        end

        // A restart from STREAM also abandons any partially framed packet.
        if (start_i && ((state_q == IDLE) || (state_q == STREAM) || (state_q == ERROR))) begin
            cmd_d      = CMD_RESET;
            retry_d    = '0;
            err_code_d = 2'd0;
            idx_d      = 2'd0;
            state_d    = TX_REQ;
        end

        tmo_d = (!counting || timeout || rx_valid_i || (state_d != state_q)) ? '0 : tmo_q + 1'b1;
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            idx_q       <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign tx_valid_o  = (state_q == TX_REQ);
    assign tx_data_o   = (state_q == TX_REQ) ? cmd_q : 8'h00;
    assign pkt_valid_o = pkt_valid_q;
    assign pkt_data_o  = pkt_data_q;
    assign ready_o     = (state_q == STREAM);
    assign busy_o      = !((state_q == IDLE) || (state_q == STREAM) || (state_q == ERROR));
    assign err_o       = (state_q == ERROR);
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb/tb_ps2_mouse_init_ctrl.sv - directed self-checking bench for ps2_mouse_init_ctrl
module tb_ps2_mouse_init_ctrl;

    logic        hclk;
    logic        hrst;
    logic        start_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        tx_done_i;
    logic        tx_err_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        pkt_valid_o;
    logic [23:0] pkt_data_o;
    logic        ready_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int tx_n     = 0;
    int pkt_n    = 0;
    logic [7:0] tx_log [64];
    int         tx_t   [64];

    ps2_mouse_init_ctrl #(.TIMEOUT_CYC(100), .MAX_RETRY(2)) dut (
        .hclk(hclk), .hrst(hrst), .start_i(start_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .tx_done_i(tx_done_i), .tx_err_i(tx_err_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .pkt_valid_o(pkt_valid_o), .pkt_data_o(pkt_data_o),
        .ready_o(ready_o), .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge hclk) begin
        if (tx_valid_o && tx_ready_i) begin
            tx_log[tx_n[5:0]] <= tx_data_o;
            tx_t[tx_n[5:0]]   <= cyc_cnt;
            tx_n              <= tx_n + 1;
        end
        if (pkt_valid_o) pkt_n <= pkt_n + 1;
    end

    function automatic logic [7:0] log_at(input int k);
        int j;
        j = k % 64;
        return tx_log[j[5:0]];
    endfunction

    function automatic int time_at(input int k);
        int j;
        j = k % 64;
        return tx_t[j[5:0]];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        cyc(1);
        rx_valid_i = 1'b0;
        cyc(1);
    endtask

    task automatic send_tx(input bit fail);
        int w;
        w = 0;
        while (tx_valid_o !== 1'b1 && w < 300) begin
            cyc(1);
            w++;
        end
        n_assert++;
        if (tx_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_offer: tx_valid_o=%b required 1 within 300 cycles", tx_valid_o);
        end else begin
            tx_ready_i = 1'b1;
            cyc(1);
            tx_ready_i = 1'b0;
            if (fail) tx_err_i = 1'b1;
            else      tx_done_i = 1'b1;
            cyc(1);
            tx_err_i  = 1'b0;
            tx_done_i = 1'b0;
        end
    endtask

    task automatic bring_up();
        pulse_start();
        send_tx(1'b0);
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        send_tx(1'b0);
        rx_byte(8'hFA);
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        cyc(3);
        n_assert++;
        if ({tx_valid_o, tx_data_o, pkt_valid_o, pkt_data_o, ready_o, busy_o, err_o, err_code_o} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {tx_valid_o, tx_data_o, pkt_valid_o, pkt_data_o, ready_o, busy_o, err_o, err_code_o});
        end
        hrst = 1'b0;
        cyc(1);
    endtask

    task automatic test_bringup();
        int base;
        base = tx_n;
        bring_up();
        n_assert++;
        if (ready_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bringup_status: ready=%b err=%b busy=%b required 1 0 0", ready_o, err_o, busy_o);
        end
        n_assert++;
        if (tx_n - base !== 2) begin
            n_fail++;
            $display("FAIL bringup_tx_count: got %0d required 2", tx_n - base);
        end
        n_assert++;
        if (log_at(base) !== 8'hFF || log_at(base + 1) !== 8'hF4) begin
            n_fail++;
            $display("FAIL bringup_tx_bytes: got %h %h required ff f4", log_at(base), log_at(base + 1));
        end
    endtask

    task automatic test_nak_retry();
        int base;
        base = tx_n;
        pulse_start();
        send_tx(1'b0);
        rx_byte(8'hFE);
        send_tx(1'b0);
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        send_tx(1'b0);
        rx_byte(8'hFA);
        n_assert++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL nak_ready: got %b required 1", ready_o);
        end
        n_assert++;
        if (tx_n - base !== 3 || log_at(base) !== 8'hFF || log_at(base + 1) !== 8'hFF || log_at(base + 2) !== 8'hF4) begin
            n_fail++;
            $display("FAIL nak_tx_seq: count=%0d bytes %h %h %h required 3 ff ff f4",
                     tx_n - base, log_at(base), log_at(base + 1), log_at(base + 2));
        end
        base = tx_n;
        pulse_start();
        send_tx(1'b0);
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        send_tx(1'b1);
        send_tx(1'b1);
        send_tx(1'b1);
        n_assert++;
        if (err_o !== 1'b1 || err_code_o !== 2'd1) begin
            n_fail++;
            $display("FAIL txerr_exhaust: err=%b code=%0d required 1 1", err_o, err_code_o);
        end
        n_assert++;
        if (tx_n - base !== 4 || log_at(base + 3) !== 8'hF4) begin
            n_fail++;
            $display("FAIL txerr_tx_seq: count=%0d last=%h required 4 f4", tx_n - base, log_at(base + 3));
        end
    endtask

    task automatic test_bat_fail();
        pulse_start();
        send_tx(1'b0);
        rx_byte(8'hFA);
        rx_byte(8'hFC);
        n_assert++;
        if (err_o !== 1'b1 || err_code_o !== 2'd2) begin
            n_fail++;
            $display("FAIL bat_fail: err=%b code=%0d required 1 2", err_o, err_code_o);
        end
        cyc(5);
        n_assert++;
        if (err_code_o !== 2'd2) begin
            n_fail++;
            $display("FAIL bat_code_hold: got %0d required 2", err_code_o);
        end
        bring_up();
        n_assert++;
        if (ready_o !== 1'b1 || err_code_o !== 2'd0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bat_recover: ready=%b code=%0d err=%b required 1 0 0", ready_o, err_code_o, err_o);
        end
    endtask

    task automatic test_bad_id();
        pulse_start();
        send_tx(1'b0);
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h03);
        n_assert++;
        if (err_o !== 1'b1 || err_code_o !== 2'd3) begin
            n_fail++;
            $display("FAIL bad_id: err=%b code=%0d required 1 3", err_o, err_code_o);
        end
    endtask

    task automatic test_no_reply();
        int base;
        int w;
        base = tx_n;
        pulse_start();
        send_tx(1'b0);
        send_tx(1'b0);
        send_tx(1'b0);
        w = 0;
        while (err_o !== 1'b1 && w < 300) begin
            cyc(1);
            w++;
        end
        n_assert++;
        if (err_o !== 1'b1 || err_code_o !== 2'd1) begin
            n_fail++;
            $display("FAIL noreply_err: err=%b code=%0d required 1 1", err_o, err_code_o);
        end
        n_assert++;
        if (tx_n - base !== 3 || log_at(base + 2) !== 8'hFF) begin
            n_fail++;
            $display("FAIL noreply_tx: count=%0d last=%h required 3 ff", tx_n - base, log_at(base + 2));
        end
        n_assert++;
        if (time_at(base + 1) - time_at(base) < 100 || time_at(base + 2) - time_at(base + 1) < 100) begin
            n_fail++;
            $display("FAIL noreply_spacing: got %0d %0d required >=100",
                     time_at(base + 1) - time_at(base), time_at(base + 2) - time_at(base + 1));
        end
    endtask

    task automatic test_stream();
        int base;
        bring_up();
        base = pkt_n;
        rx_byte(8'h05);
        rx_byte(8'h09);
        rx_byte(8'h10);
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hF0;
        cyc(1);
        rx_valid_i = 1'b0;
        n_assert++;
        if (pkt_valid_o !== 1'b1 || pkt_data_o !== 24'hF01009) begin
            n_fail++;
            $display("FAIL stream_pkt: valid=%b data=%h required 1 f01009", pkt_valid_o, pkt_data_o);
        end
        cyc(1);
        n_assert++;
        if (pkt_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_pulse_width: valid=%b required 0", pkt_valid_o);
        end
        cyc(5);
        n_assert++;
        if (pkt_n - base !== 1 || pkt_data_o !== 24'hF01009) begin
            n_fail++;
            $display("FAIL stream_hold: count=%0d data=%h required 1 f01009", pkt_n - base, pkt_data_o);
        end
    endtask

    task automatic test_timeout();
        int base;
        base = pkt_n;
        rx_byte(8'h08);
        rx_byte(8'h01);
        cyc(100);
        rx_byte(8'h08);
        rx_byte(8'h02);
        rx_byte(8'h03);
        cyc(2);
        n_assert++;
        if (pkt_n - base !== 1 || pkt_data_o !== 24'h030208) begin
            n_fail++;
            $display("FAIL gap_timeout: count=%0d data=%h required 1 030208", pkt_n - base, pkt_data_o);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = pkt_n;
        rx_byte(8'h08);
        rx_byte(8'h01);
        rx_byte(8'h02);
        rx_byte(8'h18);
        rx_byte(8'h03);
        rx_byte(8'h04);
        cyc(2);
        n_assert++;
        if (pkt_n - base !== 2 || pkt_data_o !== 24'h040318) begin
            n_fail++;
            $display("FAIL back_to_back: count=%0d data=%h required 2 040318", pkt_n - base, pkt_data_o);
        end
    endtask

    task automatic test_tx_hold_and_reset();
        bit bad;
        bad = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hFF) bad = 1'b1;
            cyc(1);
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL tx_hold: valid/data not held stable, now valid=%b data=%h required 1 ff", tx_valid_o, tx_data_o);
        end
        hrst = 1'b1;
        cyc(1);
        n_assert++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_tx: valid=%b busy=%b ready=%b err=%b required 0 0 0 0",
                     tx_valid_o, busy_o, ready_o, err_o);
        end
        hrst = 1'b0;
        cyc(1);
    endtask

    initial begin
        hrst       = 1'b1;
        start_i    = 1'b0;
        tx_ready_i = 1'b0;
        tx_done_i  = 1'b0;
        tx_err_i   = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        test_reset();
        test_bringup();
        test_nak_retry();
        test_bat_fail();
        test_bad_id();
        test_no_reply();
        test_stream();
        test_timeout();
        test_back_to_back();
        test_tx_hold_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
